// File: rtl/hacd_pkg.sv
// Shared HAWK AXI constants, packet structs and the read-responder state type.
package hacd_pkg;

    localparam int unsigned HACD_AXI4_DATA_WIDTH = 64;
    localparam int unsigned HACD_AXI4_ADDR_WIDTH = 64;
    localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] HAWK_ATT_START = 64'h0000_0000_8000_0000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [HACD_AXI4_ADDR_WIDTH-1:0] addr;
        logic [7:0]                      arlen;
        logic                            arvalid;
        logic                            rready;
    } axi_rd_reqpkt_t;

    typedef struct packed {
        logic arready;
    } axi_rd_rdypkt_t;

    typedef struct packed {
        logic                            rvalid;
        logic                            rlast;
        logic [HACD_AXI4_DATA_WIDTH-1:0] rdata;
        logic [1:0]                      rresp;
    } axi_rd_resppkt_t;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_RESP  = 2'd2
    } rsp_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hawk_axi_rd_responder_if.sv
// AXI read request / ready / response packet bundle between a read master and the responder.
interface hawk_axi_rd_responder_if;

    hacd_pkg::axi_rd_reqpkt_t  rd_reqpkt;
    hacd_pkg::axi_rd_rdypkt_t  rd_rdypkt;
    hacd_pkg::axi_rd_resppkt_t rd_resppkt;

    modport master (
        output rd_reqpkt,
        input  rd_rdypkt,
        input  rd_resppkt
    );

    modport slave (
        input  rd_reqpkt,
        output rd_rdypkt,
        output rd_resppkt
    );

endinterface

// File: rtl/hawk_rd_resp_sram.sv
// 1R1W synchronous word store with registered read and no reset (block-RAM style).
module hawk_rd_resp_sram
    import hacd_pkg::*;
#(
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned DATA_W = 64
) (
    input  logic                       clk_i,
    input  logic                       wr_en,
    input  logic [clogb2(DEPTH)-1:0]   wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [clogb2(DEPTH)-1:0]   rd_idx,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Same-cycle read of a written word returns the previous contents.
    always_ff @(posedge clk_i) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/hawk_axi_rd_responder.sv
// AXI4 single-beat / INCR-burst read responder backed by a preloadable table store.
// Optional HAWK_RD_ADDR_CHK_EN: out-of-range beats return DECERR instead of wrapping.
module hawk_axi_rd_responder
    import hacd_pkg::*;
#(
    parameter int unsigned DEPTH = 4096,
    parameter logic [HACD_AXI4_ADDR_WIDTH-1:0] BASE_ADDR = HAWK_ATT_START
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    hawk_axi_rd_responder_if.slave          rd_bus,
    input  logic                            pl_wr_en,
    input  logic [clogb2(DEPTH)-1:0]        pl_wr_idx,
    input  logic [HACD_AXI4_DATA_WIDTH-1:0] pl_wr_data,
    output logic [1:0]                      rsp_state
);

    localparam int unsigned IDX_W  = clogb2(DEPTH);
    localparam int unsigned OFF_W  = clogb2(HACD_AXI4_DATA_WIDTH / 8);
    localparam int unsigned ADDR_W = HACD_AXI4_ADDR_WIDTH;

    rsp_state_e state_q;
    logic [7:0] beat_q;
    logic [7:0] len_q;
    logic       arready_q;
    logic       rvalid_q;
    logic       rlast_q;
    logic       err_q;
    logic       beat_err;

    logic                            rd_en;
    logic [IDX_W-1:0]                rd_idx;
    logic [HACD_AXI4_DATA_WIDTH-1:0] rd_data;

`ifdef HAWK_RD_ADDR_CHK_EN
    // Full-width word index so beats past the end of the store can be detected.
    logic [ADDR_W-1:0] idx_q;
    logic              below_q;

    assign beat_err = below_q || ((idx_q + ADDR_W'(beat_q)) >= ADDR_W'(DEPTH));
    assign rd_idx   = idx_q[IDX_W-1:0] + IDX_W'(beat_q);
`else
    logic [IDX_W-1:0] idx_q;

    assign beat_err = 1'b0;
    assign rd_idx   = idx_q + IDX_W'(beat_q);
`endif

    assign rd_en = (state_q == RSP_FETCH) && !beat_err;

    hawk_rd_resp_sram #(
        .DEPTH  (DEPTH),
        .DATA_W (HACD_AXI4_DATA_WIDTH)
    ) u_sram (
        .clk_i   (clk_i),
        .wr_en   (pl_wr_en),
        .wr_idx  (pl_wr_idx),
        .wr_data (pl_wr_data),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RSP_IDLE;
            beat_q    <= 8'd0;
            len_q     <= 8'd0;
            idx_q     <= '0;
`ifdef HAWK_RD_ADDR_CHK_EN
            below_q   <= 1'b0;
`endif
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                RSP_IDLE: begin
                    arready_q <= 1'b1;
                    if (rd_bus.rd_reqpkt.arvalid && arready_q) begin
                        arready_q <= 1'b0;
`ifdef HAWK_RD_ADDR_CHK_EN
                        idx_q     <= (rd_bus.rd_reqpkt.addr - BASE_ADDR) >> OFF_W;
                        below_q   <= rd_bus.rd_reqpkt.addr < BASE_ADDR;
`else
                        idx_q     <= IDX_W'((rd_bus.rd_reqpkt.addr - BASE_ADDR) >> OFF_W);
`endif
                        len_q     <= rd_bus.rd_reqpkt.arlen;
                        beat_q    <= 8'd0;
                        state_q   <= RSP_FETCH;
                    end
                end
                RSP_FETCH: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= (beat_q == len_q);
                    err_q    <= beat_err;
                    state_q  <= RSP_RESP;
                end
                RSP_RESP: begin
                    if (rd_bus.rd_reqpkt.rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            state_q   <= RSP_IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            state_q <= RSP_FETCH;
                        end
                    end
                end
                default: state_q <= RSP_IDLE;
            endcase
        end
    end

    // Store output only changes in FETCH, so R outputs stay frozen while stalled.
    always_comb begin
        rd_bus.rd_rdypkt.arready  = arready_q;
        rd_bus.rd_resppkt.rvalid  = rvalid_q;
        rd_bus.rd_resppkt.rlast   = rvalid_q & rlast_q;
        rd_bus.rd_resppkt.rdata   = (rvalid_q && !err_q) ? rd_data : '0;
        rd_bus.rd_resppkt.rresp   = (rvalid_q && err_q) ? AXI_RESP_DECERR : AXI_RESP_OKAY;
    end

    assign rsp_state = state_q;

endmodule

// File: tb/tb_hawk_axi_rd_responder.sv
// Randomised + directed bench for hawk_axi_rd_responder against a transaction-level model.
module tb_hawk_axi_rd_responder;
    import hacd_pkg::*;

    localparam int DEPTH = 16;
    localparam int IW    = 4;
    localparam logic [63:0] BASE = HAWK_ATT_START;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          pl_wr_en = 1'b0;
    logic [IW-1:0] pl_wr_idx = '0;
    logic [63:0]   pl_wr_data = '0;
    logic [1:0]    rsp_state;

    hawk_axi_rd_responder_if rd_if();

    hawk_axi_rd_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_bus     (rd_if),
        .pl_wr_en   (pl_wr_en),
        .pl_wr_idx  (pl_wr_idx),
        .pl_wr_data (pl_wr_data),
        .rsp_state  (rsp_state)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int n_txn  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model + per-cycle compare ----------------
    logic [63:0] mdl_mem [DEPTH];
    bit          busy = 0;
    bit          rst_prev = 0;
    bit          mon_on = 0;
    int          rv_at, fetch_at, beat, len;
    logic [63:0] cur_w, wi, exp_data;
    logic        exp_err, exp_rv;
`ifdef HAWK_RD_ADDR_CHK_EN
    logic        cur_below;
`endif

    always @(negedge clk_i) begin
        exp_rv = 1'b0;
        if (mon_on) begin
            if (rst_prev) begin
                chk("m_rst_arready", rd_if.rd_rdypkt.arready, 0);
                chk("m_rst_rvalid", rd_if.rd_resppkt.rvalid, 0);
                chk("m_rst_rlast", rd_if.rd_resppkt.rlast, 0);
                chk("m_rst_rdata", rd_if.rd_resppkt.rdata, 0);
                chk("m_rst_rresp", rd_if.rd_resppkt.rresp, 0);
                chk("m_rst_state", rsp_state, 0);
            end else begin
                if (busy && cyc == fetch_at) begin
                    wi = cur_w + 64'(beat);
`ifdef HAWK_RD_ADDR_CHK_EN
                    exp_err  = cur_below || (wi >= 64'(DEPTH));
                    exp_data = exp_err ? 64'd0 : mdl_mem[wi[IW-1:0]];
`else
                    exp_err  = 1'b0;
                    exp_data = mdl_mem[wi[IW-1:0]];
`endif
                end
                exp_rv = busy && (cyc >= rv_at);
                chk("m_arready", rd_if.rd_rdypkt.arready, !busy);
                chk("m_rvalid", rd_if.rd_resppkt.rvalid, exp_rv);
                chk("m_state", rsp_state, !busy ? 0 : (exp_rv ? 2 : 1));
                if (exp_rv) begin
                    chk("m_rdata", rd_if.rd_resppkt.rdata, exp_data);
                    chk("m_rresp", rd_if.rd_resppkt.rresp, exp_err ? 2'b11 : 2'b00);
                    chk("m_rlast", rd_if.rd_resppkt.rlast, beat == len);
                end
            end
            if (!rst_ni) begin
                busy = 0;
            end else if (!rst_prev && !busy && rd_if.rd_reqpkt.arvalid) begin
                busy     = 1;
                cur_w    = (rd_if.rd_reqpkt.addr - BASE) >> 3;
`ifdef HAWK_RD_ADDR_CHK_EN
                cur_below = rd_if.rd_reqpkt.addr < BASE;
`endif
                beat     = 0;
                len      = int'(rd_if.rd_reqpkt.arlen);
                fetch_at = cyc + 1;
                rv_at    = cyc + 2;
            end else if (!rst_prev && exp_rv && rd_if.rd_reqpkt.rready) begin
                if (beat == len) begin
                    busy = 0;
                    n_txn++;
                    $display("txn %0d: %0d beats from word %0d done at cyc %0d", n_txn, len + 1, cur_w, cyc);
                end else begin
                    beat++;
                    fetch_at = cyc + 1;
                    rv_at    = cyc + 2;
                end
            end
        end
        if (pl_wr_en) mdl_mem[pl_wr_idx] = pl_wr_data;
        if (!rst_ni) mon_on = 1;
        rst_prev = !rst_ni;
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic preload(input int idx, input logic [63:0] d);
        pl_wr_en   = 1'b1;
        pl_wr_idx  = IW'(idx);
        pl_wr_data = d;
        tick();
        pl_wr_en   = 1'b0;
    endtask

    // Returns one cycle after the AR handshake cycle hs.
    task automatic do_ar(input logic [63:0] addr, input int l, output int hs);
        rd_if.rd_reqpkt.addr    = addr;
        rd_if.rd_reqpkt.arlen   = 8'(l);
        rd_if.rd_reqpkt.arvalid = 1'b1;
        hs = -1;
        for (int k = 0; k < 50; k++) begin
            if (rd_if.rd_rdypkt.arready) begin
                hs = cyc;
                break;
            end
            tick();
        end
        if (hs < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ar_timeout cyc=%0d got=no arready expected=arready within 50 cycles", cyc);
        end else begin
            tick();
        end
        rd_if.rd_reqpkt.arvalid = 1'b0;
    endtask

    task automatic expect_beat(input string nm, input logic [63:0] d, input logic [1:0] rr, input logic last);
        chk({nm, "_rvalid"}, rd_if.rd_resppkt.rvalid, 1);
        chk({nm, "_rdata"}, rd_if.rd_resppkt.rdata, d);
        chk({nm, "_rresp"}, rd_if.rd_resppkt.rresp, rr);
        chk({nm, "_rlast"}, rd_if.rd_resppkt.rlast, last);
    endtask

    function automatic logic [63:0] rand_addr();
        if ($urandom_range(0, 9) == 0)
            return BASE - 64'(8 * $urandom_range(1, 4)) - 64'($urandom_range(0, 7));
        return BASE + 64'(8 * $urandom_range(0, 23)) + 64'($urandom_range(0, 7));
    endfunction

    int  hs;
    int  rst_hold;
    bit  ar_taken;

    initial begin
        rd_if.rd_reqpkt = '0;
        rst_ni = 1'b0;
        tickn(3);
        chk("rst_arready", rd_if.rd_rdypkt.arready, 0);
        chk("rst_rvalid", rd_if.rd_resppkt.rvalid, 0);
        chk("rst_rdata", rd_if.rd_resppkt.rdata, 0);
        chk("rst_state", rsp_state, 0);
        rst_ni = 1'b1;
        tick();
        chk("rel_arready", rd_if.rd_rdypkt.arready, 1);
        for (int i = 0; i < DEPTH; i++) preload(i, {$urandom, $urandom});

        // single beat
        rd_if.rd_reqpkt.rready = 1'b1;
        preload(5, 64'hA5A5_0000_0000_0005);
        do_ar(BASE + 64'd40, 0, hs);
        tick();
        expect_beat("single", 64'hA5A5_0000_0000_0005, 2'b00, 1'b1);
        tick();
        chk("single_arready_after", rd_if.rd_rdypkt.arready, 1);

        // four-beat burst, rready held high
        for (int i = 0; i < 4; i++) preload(i, 64'h10 + 64'(i));
        do_ar(BASE, 3, hs);
        tick();
        for (int b = 0; b < 4; b++) begin
            expect_beat("burst", 64'h10 + 64'(b), 2'b00, b == 3);
            if (b < 3) begin
                tick();
                chk("burst_gap_rvalid", rd_if.rd_resppkt.rvalid, 0);
                tick();
            end
        end
        tick();

        // back-pressure on beat 1 of a two-beat burst
        rd_if.rd_reqpkt.rready = 1'b0;
        do_ar(BASE, 1, hs);
        tick();
        expect_beat("bp_b0", 64'h10, 2'b00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_beat("bp_hold", 64'h10, 2'b00, 1'b0);
        end
        tick();
        rd_if.rd_reqpkt.rready = 1'b1;
        tick();
        chk("bp_gap_rvalid", rd_if.rd_resppkt.rvalid, 0);
        tick();
        expect_beat("bp_b1", 64'h11, 2'b00, 1'b1);
        tick();

        // last word of the store, then one past it
        preload(15, 64'h0F0F);
        do_ar(BASE + 64'(15 * 8), 1, hs);
        tick();
        expect_beat("edge_b0", 64'h0F0F, 2'b00, 1'b0);
        tickn(2);
`ifdef HAWK_RD_ADDR_CHK_EN
        expect_beat("edge_b1", 64'h0, 2'b11, 1'b1);
`else
        expect_beat("edge_b1", 64'h10, 2'b00, 1'b1);
`endif
        tick();

        // reset during beat 2 of an eight-beat burst
        for (int i = 0; i < 8; i++) preload(i, 64'h100 + 64'(i));
        do_ar(BASE, 7, hs);
        tickn(3);
        expect_beat("rstmid_b1", 64'h101, 2'b00, 1'b0);
        rst_ni = 1'b0;
        tick();
        chk("rstmid_rvalid", rd_if.rd_resppkt.rvalid, 0);
        tick();
        rst_ni = 1'b1;
        tickn(3);
        chk("rstmid_post_rvalid", rd_if.rd_resppkt.rvalid, 0);
        do_ar(BASE + 64'd16, 0, hs);
        tick();
        expect_beat("rstmid_fresh", 64'h102, 2'b00, 1'b1);
        tick();

        // preload collides with the FETCH of the same word
        preload(7, 64'hCAFE);
        do_ar(BASE + 64'd56, 0, hs);
        pl_wr_en = 1'b1; pl_wr_idx = 4'd7; pl_wr_data = 64'hBEEF;
        tick();
        pl_wr_en = 1'b0;
        expect_beat("collide_old", 64'hCAFE, 2'b00, 1'b1);
        tick();
        do_ar(BASE + 64'd56, 0, hs);
        tick();
        expect_beat("collide_new", 64'hBEEF, 2'b00, 1'b1);
        tick();

        // maximum-length burst, checked by the model
        do_ar(BASE + 64'd24, 255, hs);
        tickn(520);

        // randomised traffic
        rst_hold = 0;
        for (int k = 0; k < 4000; k++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_ni = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_ni   = 1'b0;
                rst_hold = 2;
            end
            rd_if.rd_reqpkt.rready = ($urandom_range(0, 3) != 0);
            pl_wr_en   = ($urandom_range(0, 2) == 0);
            pl_wr_idx  = IW'($urandom_range(0, DEPTH - 1));
            pl_wr_data = {$urandom, $urandom};
            if (!rd_if.rd_reqpkt.arvalid && $urandom_range(0, 3) == 0) begin
                rd_if.rd_reqpkt.arvalid = 1'b1;
                rd_if.rd_reqpkt.addr    = rand_addr();
                rd_if.rd_reqpkt.arlen   = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 40))
                                                                       : 8'($urandom_range(0, 3));
            end
            ar_taken = rd_if.rd_reqpkt.arvalid && rd_if.rd_rdypkt.arready && rst_ni;
            tick();
            if (ar_taken) rd_if.rd_reqpkt.arvalid = 1'b0;
        end
        rd_if.rd_reqpkt.arvalid = 1'b0;
        rd_if.rd_reqpkt.rready  = 1'b1;
        pl_wr_en = 1'b0;
        rst_ni   = 1'b1;
        tickn(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hawk_axi_rd_responder.md
# hawk_axi_rd_responder

AXI4 read-channel responder serving the single-beat and INCR-burst reads issued by the hawk page read manager, its compression/decompression helpers and the compacter. It returns data from an on-chip table store of ATT/TOL/page words, preloaded over a simple write port, and completes the `rd_reqpkt` / `rd_rdypkt` / `rd_resppkt` packet interface from the slave side. It is used in HAWK_SIMS benches and in FPGA builds without DDR.

## Interface
- `DEPTH`, 4096: number of `HACD_AXI4_DATA_WIDTH` words in the store; must be a power of 2.
- `BASE_ADDR`, `HAWK_ATT_START`: byte address that maps to word 0.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Synchronous, active-low; one clock, `clk_i`.
- `rd_reqpkt`  in  `hacd_pkg::axi_rd_reqpkt_t`  fields `addr`, `arlen`, `arvalid`, `rready`.
- `rd_rdypkt`  out  `hacd_pkg::axi_rd_rdypkt_t`  field `arready`.
- `rd_resppkt`  out  `hacd_pkg::axi_rd_resppkt_t`  fields `rvalid`, `rlast`, `rdata`, `rresp`.
- `pl_wr_en`  in  1  preload write strobe.
- `pl_wr_idx`  in  clogb2(DEPTH)  preload word index.
- `pl_wr_data`  in  `HACD_AXI4_DATA_WIDTH`  preload data.
- `rsp_state`  out  2  FSM state, for debug.

## Operation
- Word index: `idx = (addr - BASE_ADDR) >> clogb2(HACD_AXI4_DATA_WIDTH/8)`. Low address bits are ignored; unaligned addresses are not flagged.
- FSM has three states: IDLE=0, FETCH=1, RESP=2.
  - IDLE: `arready=1`. On `arvalid&&arready`: capture `idx`, capture `arlen` into `len_q`, clear `beat_q`, go to FETCH.
  - FETCH: `arready=0`. Registered store read of `idx+beat_q`, go to RESP.
  - RESP: `rvalid=1`, and `rlast=(beat_q==len_q)`. `rdata` and `rresp` are held stable until `rready`.
  - On `rready` in RESP: if last beat, go to IDLE; otherwise `beat_q++` and go to FETCH.
- Bursts are INCR only, with `arlen+1` beats and `arlen` up to 255. `beat_q` is 8 bits.
- Only one outstanding transaction. `arready` is low outside IDLE.
- Preload port is independent of the FSM and can be written in any state. A preload write to the same index as a FETCH in the same cycle returns the old data (read-before-write).
- Store contents are not cleared by reset.

## Timing
- Reset values: `arready=0` during reset and `1` from the first cycle after release; `rvalid=0`, `rlast=0`, `rdata=0`, `rresp=0`, `rsp_state=IDLE`.
- AR handshake in cycle N → first `rvalid` in cycle N+2.
- Each further beat: `rvalid` rises 2 cycles after the previous `rready` handshake. `rvalid` is low in the FETCH cycle between beats.
- After the last-beat handshake, `arready=1` in the next cycle.
- Back-pressure: `rready` low holds RESP indefinitely, with all R outputs frozen.
- Reset mid-burst: the remaining beats are dropped. `rvalid` goes low the cycle after `rst_ni` is sampled low, and no stale beat appears after release.
- `arvalid` seen outside IDLE is not acknowledged; the master must hold it.

## Configuration
- `HAWK_RD_ADDR_CHK_EN` defined: a beat whose address is below `BASE_ADDR`, or whose `idx+beat_q >= DEPTH`, returns `rresp=2'b11` (DECERR) and `rdata=0`. The burst still completes all `arlen+1` beats, each checked independently. The store is not read for erroring beats.
- Undefined: the index wraps modulo `DEPTH`, and `rresp` is always `2'b00`.

## Structure
- In `hacd_pkg`:
  - constants `AXI_RESP_OKAY=2'b00` and `AXI_RESP_DECERR=2'b11`;
  - the responder state typedef (IDLE/FETCH/RESP).
- Packet structs are reused unchanged from `hacd_pkg`.
- One sub-module: `hawk_rd_resp_sram`, a 1R1W synchronous store of `DEPTH`×`HACD_AXI4_DATA_WIDTH`. It has registered read and no reset, and is inferable as BRAM.

## Test plan
- Single beat: preload idx 5=`64'hA5A5_0000_0000_0005`; AR with `addr=BASE_ADDR+40`, `arlen=0` in cycle N → `rvalid=1`, `rlast=1`, that data, `rresp=0` in cycle N+2; `arready=1` in N+3.
- Burst: preload idx 0..3 = 0x10..0x13; AR with `arlen=3` and `rready` held high → four beats 0x10..0x13 in cycles N+2, N+4, N+6, N+8, with `rlast` only on 0x13.
- Back-pressure: drop `rready` for 5 cycles on beat 1 of an `arlen=1` burst → `rvalid` and `rdata` stable throughout; beat 2 appears 2 cycles after `rready` returns.
- Range check (macro on, `DEPTH=16`): AR at idx 15 with `arlen=1` → beat 0 is OKAY with data; beat 1 is DECERR with `rdata=0` and `rlast=1`. Macro off → beat 1 returns idx 0 data with OKAY.
- Reset mid-burst: assert `rst_ni=0` during beat 2 of an `arlen=7` burst → `rvalid=0` next cycle; after release, a fresh AR returns correct data with no leftover beats.
- Collision: preload write to idx 7 with 0xBEEF in the same cycle as FETCH of idx 7 (old value 0xCAFE) → 0xCAFE returned; a subsequent read returns 0xBEEF.
